// File: rtl/alu_issue_pkg.sv
// Shared widths, FSM state encoding and flag layout for the ALU issue unit.
// The optional carry-chain feature is enabled by defining ALU_ISSUE_CARRY_CHAIN_EN.
package alu_issue_pkg;

    localparam int DATA_W = 8;
    localparam int FUNC_W = 3;
    localparam int FLAG_W = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    // Bit order carry/zero/neg matches the {carry, zero, neg} packing used everywhere.
    typedef struct packed {
        logic carry;
        logic zero;
        logic neg;
    } flags_t;

endpackage

// File: rtl/alu_issue_flags.sv
// Three-bit flag register (carry, zero, neg) with load enable and async reset.
module alu_issue_flags
    import alu_issue_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   load,
    input  flags_t flags_in,
    output flags_t flags_out
);

    flags_t flags_q;
    flags_t flags_d;

    always_comb begin
        flags_d = flags_q;
        if (load) begin
            flags_d = flags_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q <= '0;
        end else begin
            flags_q <= flags_d;
        end
    end

    assign flags_out = flags_q;

endmodule

// File: rtl/alu_issue_unit.sv
// Issues one request at a time to an external combinational ALU and returns its result.
// Define ALU_ISSUE_CARRY_CHAIN_EN to add reqUseCarry for multi-byte carry chaining.
module alu_issue_unit
    import alu_issue_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // valid never waits on ready, and a producer holds its payload stable while valid is high.
    input  logic              reqValid,
    output logic              reqReady,
    input  logic [DATA_W-1:0] reqA,
    input  logic [DATA_W-1:0] reqB,
    input  logic [FUNC_W-1:0] reqFunc,
    input  logic              reqCarryIn,
`ifdef ALU_ISSUE_CARRY_CHAIN_EN
    input  logic              reqUseCarry,
`endif
    output logic [DATA_W-1:0] inputA,
    output logic [DATA_W-1:0] inputB,
    output logic              carryIn,
    output logic [FUNC_W-1:0] func,
    input  logic [DATA_W-1:0] result,
    input  logic              carryOut,
    input  logic              zero,
    input  logic              negetive,
    output logic              rspValid,
    input  logic              rspReady,
    output logic [DATA_W-1:0] rspResult,
    output logic              rspCarry,
    output logic              rspZero,
    output logic              rspNeg,
    output state_e            dbg_state,
    output flags_t            dbg_flags
);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] input_a_q, input_a_d;
    logic [DATA_W-1:0] input_b_q, input_b_d;
    logic [FUNC_W-1:0] func_q, func_d;
    logic              carry_in_q, carry_in_d;
    logic [DATA_W-1:0] rsp_result_q, rsp_result_d;
    logic              rsp_carry_q, rsp_carry_d;
    logic              rsp_zero_q, rsp_zero_d;
    logic              rsp_neg_q, rsp_neg_d;
    logic              flag_load;
    flags_t            flags_new;
    flags_t            flag_state;
    logic              issue_cin;

`ifdef ALU_ISSUE_CARRY_CHAIN_EN
    assign issue_cin = reqUseCarry ? flag_state.carry : reqCarryIn;
`else
    assign issue_cin = reqCarryIn;
`endif

    always_comb begin
        state_d      = state_q;
        input_a_d    = input_a_q;
        input_b_d    = input_b_q;
        func_d       = func_q;
        carry_in_d   = carry_in_q;
        rsp_result_d = rsp_result_q;
        rsp_carry_d  = rsp_carry_q;
        rsp_zero_d   = rsp_zero_q;
        rsp_neg_d    = rsp_neg_q;
        flag_load    = 1'b0;
        flags_new    = '{carry: carryOut, zero: zero, neg: negetive};

        case (state_q)
            IDLE: begin
                if (reqValid) begin
                    input_a_d  = reqA;
                    input_b_d  = reqB;
                    func_d     = reqFunc;
                    carry_in_d = issue_cin;
                    state_d    = EXEC;
                end
            end
            // ALU operands have been stable for a full cycle; capture its outputs.
            EXEC: begin
                rsp_result_d = result;
                rsp_carry_d  = carryOut;
                rsp_zero_d   = zero;
                rsp_neg_d    = negetive;
                flag_load    = 1'b1;
                state_d      = RESP;
            end
            RESP: begin
                if (rspReady) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            input_a_q    <= '0;
            input_b_q    <= '0;
            func_q       <= '0;
            carry_in_q   <= 1'b0;
            rsp_result_q <= '0;
            rsp_carry_q  <= 1'b0;
            rsp_zero_q   <= 1'b0;
            rsp_neg_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            input_a_q    <= input_a_d;
            input_b_q    <= input_b_d;
            func_q       <= func_d;
            carry_in_q   <= carry_in_d;
            rsp_result_q <= rsp_result_d;
            rsp_carry_q  <= rsp_carry_d;
            rsp_zero_q   <= rsp_zero_d;
            rsp_neg_q    <= rsp_neg_d;
        end
    end

    alu_issue_flags u_flags (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (flag_load),
        .flags_in  (flags_new),
        .flags_out (flag_state)
    );

    assign reqReady  = (state_q == IDLE);
    assign rspValid  = (state_q == RESP);
    assign inputA    = input_a_q;
    assign inputB    = input_b_q;
    assign func      = func_q;
    assign carryIn   = carry_in_q;
    assign rspResult = rsp_result_q;
    assign rspCarry  = rsp_carry_q;
    assign rspZero   = rsp_zero_q;
    assign rspNeg    = rsp_neg_q;
    assign dbg_state = state_q;
    assign dbg_flags = flag_state;

endmodule
